// File: rtl/ipml_fifo_rd_stream_pkg.sv
// Shared types and constants for the FIFO read-side stream engine.
package ipml_fifo_rd_stream_pkg;

   typedef enum logic [1:0] {
      StIdle   = 2'd0,
      StStream = 2'd1,
      StFlush  = 2'd2
   } rd_state_e;

   localparam int unsigned SKID_DEPTH = 4;

endpackage

// File: rtl/ipml_skid_buf4.sv
// Four-entry register FIFO with first-word-fall-through head.
module ipml_skid_buf4
   import ipml_fifo_rd_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] head,
   output logic [2:0]            occ
);

   logic [DATA_WIDTH-1:0] mem_q [SKID_DEPTH];
   logic [1:0]            wptr_q;
   logic [1:0]            rptr_q;
   logic [2:0]            occ_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SKID_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else if (clr) begin
         wptr_q <= '0;
         rptr_q <= '0;
         occ_q  <= '0;
      end else begin
         if (push) begin
            mem_q[wptr_q] <= push_data;
            wptr_q        <= wptr_q + 2'd1;
         end
         if (pop) begin
            rptr_q <= rptr_q + 2'd1;
         end
         case ({push, pop})
            2'b10:   occ_q <= occ_q + 3'd1;
            2'b01:   occ_q <= occ_q - 3'd1;
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign head = mem_q[rptr_q];
   assign occ  = occ_q;

   // Upstream credit accounting must make these unreachable.
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !clr && occ_q == 3'(SKID_DEPTH)));
   a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && !clr && occ_q == 3'd0));

endmodule

// File: rtl/ipml_fifo_rd_stream.sv
// Drains the FIFO read port into a valid/ready stream, hiding the FIFO read
// latency behind a credit-limited four-entry skid buffer.
module ipml_fifo_rd_stream
   import ipml_fifo_rd_stream_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst_n,
   output logic                  fifo_rd_en,
   output logic                  fifo_rd_oce,
   input  logic                  fifo_rd_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [2:0]            buf_level,
   output logic [CNT_WIDTH-1:0]  pop_cnt
);

   rd_state_e             state_q, state_d;
   logic [RD_LATENCY-1:0] infl_sr_q, infl_sr_d;
   logic [1:0]            flush_cnt_q, flush_cnt_d;
   logic                  run_q;
   logic [CNT_WIDTH-1:0]  pop_cnt_q;

   logic [2:0] occ;
   logic [2:0] infl;
   logic [2:0] credit_used;
   logic       arrive;
   logic       clr;
   logic       push;
   logic       xfer;

   assign infl        = 3'($countones(infl_sr_q));
   assign credit_used = occ + infl;
   assign arrive      = infl_sr_q[RD_LATENCY-1];
   assign clr         = flush || (state_q == StFlush);
   assign push        = arrive && !clr;
   assign m_valid     = (occ != 3'd0);
   assign xfer        = m_valid && m_ready;

   // Issue depends only on registered state, never on m_ready.
   assign fifo_rd_en  = run_q && !fifo_rd_empty && !clr && (credit_used < 3'(SKID_DEPTH));
   assign fifo_rd_oce = 1'b1;

   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      infl_sr_d   = clr ? '0 : ((infl_sr_q << 1) | RD_LATENCY'(fifo_rd_en));
      case (state_q)
         StIdle: begin
            if (fifo_rd_en) begin
               state_d = StStream;
            end
         end
         StStream: begin
            if (occ == 3'd0 && infl == 3'd0 && !fifo_rd_en) begin
               state_d = StIdle;
            end
         end
         StFlush: begin
            // Stay long enough for every pre-flush pop to have landed.
            if (flush) begin
               flush_cnt_d = '0;
            end else if (flush_cnt_q == 2'(RD_LATENCY - 1)) begin
               state_d     = StIdle;
               flush_cnt_d = '0;
            end else begin
               flush_cnt_d = flush_cnt_q + 2'd1;
            end
         end
         default: state_d = StIdle;
      endcase
      if (flush) begin
         state_d     = StFlush;
         flush_cnt_d = '0;
      end
   end

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         state_q     <= StIdle;
         infl_sr_q   <= '0;
         flush_cnt_q <= '0;
         run_q       <= 1'b0;
         pop_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         infl_sr_q   <= infl_sr_d;
         flush_cnt_q <= flush_cnt_d;
         run_q       <= 1'b1;
         if (xfer) begin
            pop_cnt_q <= pop_cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   ipml_skid_buf4 #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .clk       (rd_clk),
      .rst_n     (rd_rst_n),
      .clr       (clr),
      .push      (push),
      .push_data (fifo_rd_data),
      .pop       (xfer),
      .head      (m_data),
      .occ       (occ)
   );

   assign buf_level = occ;
   assign pop_cnt   = pop_cnt_q;

endmodule
